// File: rtl/rcc_osc_en_req_ctrl_pkg.sv
// Shared definitions for the RCC oscillator enable/ready handshake controller:
// channel state encoding, default timeout and source index map.
package rcc_osc_en_req_ctrl_pkg;

  localparam int unsigned NUM_SRC_DEF = 11;
  localparam int unsigned TMO_W_DEF   = 16;
  localparam int unsigned TMO_CYC_DEF = 32'h0000_FFFF;

  // Source index map into the per-source vectors
  localparam int unsigned IDX_HSI   = 0;
  localparam int unsigned IDX_CSI   = 1;
  localparam int unsigned IDX_HSI48 = 2;
  localparam int unsigned IDX_HSE   = 3;
  localparam int unsigned IDX_LSI   = 4;
  localparam int unsigned IDX_LSE   = 5;
  localparam int unsigned IDX_PLL1  = 6;
  localparam int unsigned IDX_PLL2  = 7;
  localparam int unsigned IDX_PLL3  = 8;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_START = 3'd1,
    ST_ON    = 3'd2,
    ST_STOP  = 3'd3,
    ST_FAULT = 3'd4
  } osc_state_e;

  // A channel is busy while a handshake with the analog source is outstanding
  function automatic logic is_busy(input osc_state_e st);
    return (st == ST_START) || (st == ST_STOP);
  endfunction

endpackage

// File: rtl/rcc_osc_en_fsm.sv
// One clock-source channel: enable/ready handshake FSM, start/stop timeout counter and status flags.
// RCC_OSC_LOST_DET_EN adds a sticky ready-lost flag.
module rcc_osc_en_fsm
  import rcc_osc_en_req_ctrl_pkg::*;
#(
  parameter int unsigned TMO_W   = TMO_W_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic on_eff,
  input  logic sync_rdy,
  input  logic timeout_clr,
  output logic osc_en,
  output logic rdy_flag,
  output logic rdy_irq,
  output logic timeout,
`ifdef RCC_OSC_LOST_DET_EN
  output logic lost,
`endif
  output logic busy_nxt_c
);

  localparam logic [TMO_W-1:0] CNT_MAX = TMO_W'(TMO_CYC - 1);

  osc_state_e       state, state_nxt;
  logic [TMO_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             tmo_set, lost_set;
  logic             osc_en_nxt, rdy_flag_nxt, rdy_irq_nxt, timeout_nxt;

  // Saturating increment; the counter never wraps
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + TMO_W'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tmo_set   = 1'b0;
    lost_set  = 1'b0;
    case (state)
      ST_OFF: begin
        if (on_eff) begin
          state_nxt = ST_START;
          cnt_nxt   = '0;
        end
      end
      ST_START: begin
        if (sync_rdy) begin
          state_nxt = ST_ON;
        end else if (!on_eff) begin
          state_nxt = ST_STOP;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_FAULT;
          tmo_set   = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_ON: begin
        if (!on_eff) begin
          state_nxt = ST_STOP;
          cnt_nxt   = '0;
        end else if (!sync_rdy) begin
          state_nxt = ST_START;
          cnt_nxt   = '0;
          lost_set  = 1'b1;
        end
      end
      ST_STOP: begin
        // A re-request is held off until the source has really stopped
        if (!sync_rdy) begin
          state_nxt = ST_OFF;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_OFF;
          tmo_set   = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_FAULT: begin
        if (!timeout) state_nxt = ST_OFF;
      end
      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = '0;
      end
    endcase

    osc_en_nxt   = (state_nxt == ST_START) || (state_nxt == ST_ON);
    rdy_flag_nxt = (state_nxt == ST_ON);
    rdy_irq_nxt  = (state == ST_START) && (state_nxt == ST_ON);
    timeout_nxt  = tmo_set | (timeout & ~timeout_clr);
    busy_nxt_c   = is_busy(state_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_OFF;
      cnt      <= '0;
      osc_en   <= 1'b0;
      rdy_flag <= 1'b0;
      rdy_irq  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      osc_en   <= osc_en_nxt;
      rdy_flag <= rdy_flag_nxt;
      rdy_irq  <= rdy_irq_nxt;
      timeout  <= timeout_nxt;
    end
  end

`ifdef RCC_OSC_LOST_DET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lost <= 1'b0;
    else     lost <= lost_set | (lost & ~timeout_clr);
  end
`else
  logic unused_lost;
  assign unused_lost = lost_set;
`endif

endmodule

// File: rtl/rcc_osc_en_req_ctrl.sv
// RCC oscillator/PLL enable request controller: one handshake channel per clock source plus global busy.
// RCC_OSC_LOST_DET_EN adds the osc_lost port.
module rcc_osc_en_req_ctrl
  import rcc_osc_en_req_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned TMO_W   = TMO_W_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic               rcc_rcc_hclk,
  input  logic               rcc_rcc_sync_rst,
  input  logic [NUM_SRC-1:0] osc_on_req,
  input  logic [NUM_SRC-1:0] osc_force_on,
  input  logic [NUM_SRC-1:0] sync_rdy,
  input  logic [NUM_SRC-1:0] timeout_clr,
  output logic [NUM_SRC-1:0] osc_en,
  output logic [NUM_SRC-1:0] osc_rdy_flag,
  output logic [NUM_SRC-1:0] osc_rdy_irq,
  output logic [NUM_SRC-1:0] osc_timeout,
`ifdef RCC_OSC_LOST_DET_EN
  output logic [NUM_SRC-1:0] osc_lost,
`endif
  output logic               busy
);

  logic [NUM_SRC-1:0] on_eff;
  logic [NUM_SRC-1:0] busy_nxt;

  assign on_eff = osc_on_req | osc_force_on;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
    rcc_osc_en_fsm #(
      .TMO_W   (TMO_W),
      .TMO_CYC (TMO_CYC)
    ) u_fsm (
      .clk         (rcc_rcc_hclk),
      .rst         (rcc_rcc_sync_rst),
      .on_eff      (on_eff[i]),
      .sync_rdy    (sync_rdy[i]),
      .timeout_clr (timeout_clr[i]),
      .osc_en      (osc_en[i]),
      .rdy_flag    (osc_rdy_flag[i]),
      .rdy_irq     (osc_rdy_irq[i]),
      .timeout     (osc_timeout[i]),
`ifdef RCC_OSC_LOST_DET_EN
      .lost        (osc_lost[i]),
`endif
      .busy_nxt_c  (busy_nxt[i])
    );
  end

  // Registered from next-state so busy carries no combinational path to the register block
  always_ff @(posedge rcc_rcc_hclk or posedge rcc_rcc_sync_rst) begin
    if (rcc_rcc_sync_rst) busy <= 1'b0;
    else                  busy <= |busy_nxt;
  end

endmodule

// File: tb/tb_rcc_osc_en_req_ctrl.sv
// Directed, table-driven bench for rcc_osc_en_req_ctrl (TMO_CYC=16); honours RCC_OSC_LOST_DET_EN.
module tb_rcc_osc_en_req_ctrl;
  import rcc_osc_en_req_ctrl_pkg::*;

  localparam int unsigned N   = 11;
  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] on_req, force_on, rdy, clr;
  logic [N-1:0] en, rdy_flag, irq, tmo;
`ifdef RCC_OSC_LOST_DET_EN
  logic [N-1:0] lost;
`endif
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  rcc_osc_en_req_ctrl #(.NUM_SRC(N), .TMO_W(16), .TMO_CYC(TMO)) dut (
    .rcc_rcc_hclk     (clk),
    .rcc_rcc_sync_rst (rst),
    .osc_on_req       (on_req),
    .osc_force_on     (force_on),
    .sync_rdy         (rdy),
    .timeout_clr      (clr),
    .osc_en           (en),
    .osc_rdy_flag     (rdy_flag),
    .osc_rdy_irq      (irq),
    .osc_timeout      (tmo),
`ifdef RCC_OSC_LOST_DET_EN
    .osc_lost         (lost),
`endif
    .busy             (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs applied in a cycle, expected outputs after the following rising edge
  typedef struct packed {
    logic on, frc, rd, cl;
    logic e_en, e_rf, e_irq, e_to, e_busy;
  } vec_t;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ch0(input string tag, input logic e_en, input logic e_rf,
                         input logic e_irq, input logic e_to, input logic e_busy);
    chk({tag, ".en"},   en,       N'(e_en));
    chk({tag, ".rdy"},  rdy_flag, N'(e_rf));
    chk({tag, ".irq"},  irq,      N'(e_irq));
    chk({tag, ".tmo"},  tmo,      N'(e_to));
    chk({tag, ".busy"}, N'(busy), N'(e_busy));
  endtask

  task automatic drive_ch0(input logic o, input logic f, input logic r, input logic c);
    on_req = '0; force_on = '0; rdy = '0; clr = '0;
    on_req[IDX_HSI]   = o;
    force_on[IDX_HSI] = f;
    rdy[IDX_HSI]      = r;
    clr[IDX_HSI]      = c;
  endtask

  vec_t vecs[28];
  logic [N-1:0] even_mask;

  initial begin
    // on frc rd cl | en rf irq to busy
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0}; // idle
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1}; // request -> START
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[7]  = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0}; // ready -> ON + irq
    vecs[8]  = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0}; // irq is one cycle
    vecs[9]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1}; // off -> STOP
    vecs[10] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1};
    vecs[11] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0}; // ready gone -> OFF
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1}; // force_on -> START
    vecs[14] = '{1'b0,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[15] = '{1'b0,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0}; // force keeps ON
    vecs[16] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1}; // STOP
    vecs[17] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1}; // re-request ignored
    vecs[18] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1};
    vecs[19] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0}; // -> OFF
    vecs[20] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1}; // OFF -> START
    vecs[21] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[22] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    vecs[23] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1}; // ready glitch -> START
    vecs[24] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0}; // second irq
    vecs[25] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    vecs[26] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1};
    vecs[27] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};

    rst = 1'b1;
    drive_ch0(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk_ch0("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef RCC_OSC_LOST_DET_EN
    chk("reset.lost", lost, '0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      drive_ch0(vecs[i].on, vecs[i].frc, vecs[i].rd, vecs[i].cl);
      step();
      chk_ch0($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_rf,
              vecs[i].e_irq, vecs[i].e_to, vecs[i].e_busy);
    end
`ifdef RCC_OSC_LOST_DET_EN
    chk("glitch.lost", lost, N'(1));
`endif

    // Start timeout: ready never rises; FAULT after 16 START cycles, clear coincides with set
    drive_ch0(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_ch0("tmo.enter", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < int'(TMO); k++) begin
      step();
      chk_ch0($sformatf("tmo.start%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    drive_ch0(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk_ch0("tmo.set_wins", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_ch0(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_ch0("tmo.fault_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_ch0(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk_ch0("tmo.cleared", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef RCC_OSC_LOST_DET_EN
    chk("tmo.lost_clr", lost, '0);
`endif
    drive_ch0(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_ch0("tmo.off", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_ch0("tmo.restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_ch0(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_ch0("tmo.abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_ch0("tmo.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // All channels: even channels become ready, then async reset mid-START
    for (int i = 0; i < int'(N); i++) even_mask[i] = (i % 2 == 0);
    on_req = '1; force_on = '0; clr = '0; rdy = even_mask;
    step();
    chk("all.start.en", en, '1);
    chk("all.start.busy", N'(busy), N'(1));
    step();
    chk("all.on.rdy", rdy_flag, even_mask);
    chk("all.on.irq", irq, even_mask);
    chk("all.on.en", en, '1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.en", en, '0);
    chk("arst.rdy", rdy_flag, '0);
    chk("arst.irq", irq, '0);
    chk("arst.tmo", tmo, '0);
    chk("arst.busy", N'(busy), '0);
    on_req = '0; rdy = '0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst.en", en, '0);
    chk("post_rst.busy", N'(busy), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
